// File: rtl/cam_ctrl_pkg.sv
// rtl/cam_ctrl_pkg.sv - shared types and defaults for the camera exposure/readout control
package cam_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, EXPOSE, READ} state_t;
   typedef enum logic [1:0] {PRE, CONV, POST, GAP} phase_t;

   localparam int NUM_ROWS_DEF   = 2;
   localparam int EXP_W_DEF      = 5;
   localparam int ADC_CYCLES_DEF = 1;

   // Index width that never collapses to zero bits for a single-row array.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/exposure_readout_ctrl_if.sv
// rtl/exposure_readout_ctrl_if.sv - frame request/status and pixel-array drive bundle
interface exposure_readout_ctrl_if #(
   parameter int NUM_ROWS = cam_ctrl_pkg::NUM_ROWS_DEF,
   parameter int EXP_W    = cam_ctrl_pkg::EXP_W_DEF
);
   localparam int ROW_W = cam_ctrl_pkg::idx_w(NUM_ROWS);

   logic                Init;
   logic [EXP_W-1:0]    ExpTime;
   logic                Abort;
   logic                Erase;
   logic                Expose;
   logic [NUM_ROWS-1:0] NRE;
   logic                ADC;
   logic                Busy;
   logic                Done;
   logic [ROW_W-1:0]    RowIdx;

   modport master (
      output Init, ExpTime, Abort,
      input  Erase, Expose, NRE, ADC, Busy, Done, RowIdx
   );

   modport slave (
      input  Init, ExpTime, Abort,
      output Erase, Expose, NRE, ADC, Busy, Done, RowIdx
   );

endinterface

// File: rtl/exposure_readout_ctrl_cycle_timer.sv
// rtl/exposure_readout_ctrl_cycle_timer.sv - loadable saturating down-counter with zero flag
module cycle_timer #(
   parameter int W = 5
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Load,
   input  logic [W-1:0] LoadVal,
   input  logic         Dec,
   output logic         Zero
);
   logic [W-1:0] count;

   always_ff @(posedge Clk) begin
      if (Reset)
         count <= '0;
      else if (Load)
         count <= LoadVal;
      else if (Dec && count != '0)
         count <= count - W'(1);
   end

   assign Zero = (count == '0);

endmodule

// File: rtl/exposure_readout_ctrl.sv
// rtl/exposure_readout_ctrl.sv - erase/expose/row-readout sequencer for the pixel array
module exposure_readout_ctrl
   import cam_ctrl_pkg::*;
#(
   parameter int NUM_ROWS   = NUM_ROWS_DEF,
   parameter int EXP_W      = EXP_W_DEF,
   parameter int ADC_CYCLES = ADC_CYCLES_DEF
) (
   input  logic Clk,
   input  logic Reset,
   exposure_readout_ctrl_if.slave bus
);
   localparam int ROW_W = idx_w(NUM_ROWS);
   localparam int PH_W  = $clog2(ADC_CYCLES + 1);
   localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(NUM_ROWS - 1);
   localparam logic [PH_W-1:0]  CONV_LOAD = PH_W'(ADC_CYCLES - 1);

   state_t            state, state_n;
   phase_t            phase, phase_n;
   logic [ROW_W-1:0]  row, row_n;
   logic              exp_load, exp_dec, exp_zero;
   logic              conv_load, conv_dec, conv_zero;
   logic              done_n;
   logic [NUM_ROWS-1:0] nre_n;
   logic [EXP_W-1:0]  exp_load_val;

   // Timer holds remaining cycles after the current one, so a request of 0 behaves as 1.
   assign exp_load_val = (bus.ExpTime == '0) ? '0 : bus.ExpTime - EXP_W'(1);

   cycle_timer #(.W(EXP_W)) u_exp_timer (
      .Clk     (Clk),
      .Reset   (Reset),
      .Load    (exp_load),
      .LoadVal (exp_load_val),
      .Dec     (exp_dec),
      .Zero    (exp_zero)
   );

   cycle_timer #(.W(PH_W)) u_conv_timer (
      .Clk     (Clk),
      .Reset   (Reset),
      .Load    (conv_load),
      .LoadVal (CONV_LOAD),
      .Dec     (conv_dec),
      .Zero    (conv_zero)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
         phase <= PRE;
         row   <= '0;
      end else begin
         state <= state_n;
         phase <= phase_n;
         row   <= row_n;
      end
   end

   always_comb begin
      state_n   = state;
      phase_n   = phase;
      row_n     = row;
      exp_load  = 1'b0;
      exp_dec   = 1'b0;
      conv_load = 1'b0;
      conv_dec  = 1'b0;
      done_n    = 1'b0;
      nre_n     = '1;

      case (state)
         IDLE: begin
            if (bus.Init && !bus.Abort) begin
               state_n  = EXPOSE;
               exp_load = 1'b1;
            end
         end
         EXPOSE: begin
            if (bus.Abort) begin
               state_n = IDLE;
            end else if (exp_zero) begin
               state_n = READ;
               phase_n = PRE;
               row_n   = '0;
            end else begin
               exp_dec = 1'b1;
            end
         end
         READ: begin
            if (bus.Abort) begin
               state_n = IDLE;
               phase_n = PRE;
               row_n   = '0;
            end else begin
               case (phase)
                  PRE: begin
                     phase_n   = CONV;
                     conv_load = 1'b1;
                  end
                  CONV: begin
                     if (conv_zero)
                        phase_n = POST;
                     else
                        conv_dec = 1'b1;
                  end
                  POST: phase_n = GAP;
                  GAP: begin
                     // Row only advances below the last row, so it can never wrap.
                     if (row == LAST_ROW) begin
                        state_n = IDLE;
                        phase_n = PRE;
                        row_n   = '0;
                        done_n  = 1'b1;
                     end else begin
                        phase_n = PRE;
                        row_n   = row + ROW_W'(1);
                     end
                  end
               endcase
            end
         end
         default: begin
            state_n = IDLE;
            phase_n = PRE;
            row_n   = '0;
         end
      endcase

      if (state_n == READ && phase_n != GAP)
         nre_n[row_n] = 1'b0;
   end

   // Outputs are registered copies of the decode of the next state.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         bus.Erase  <= 1'b1;
         bus.Expose <= 1'b0;
         bus.NRE    <= '1;
         bus.ADC    <= 1'b0;
         bus.Busy   <= 1'b0;
         bus.Done   <= 1'b0;
         bus.RowIdx <= '0;
      end else begin
         bus.Erase  <= (state_n == IDLE);
         bus.Expose <= (state_n == EXPOSE);
         bus.NRE    <= nre_n;
         bus.ADC    <= (state_n == READ) && (phase_n == CONV);
         bus.Busy   <= (state_n != IDLE);
         bus.Done   <= done_n;
         bus.RowIdx <= (state_n == READ) ? row_n : '0;
      end
   end

endmodule

// File: tb/tb_exposure_readout_ctrl.sv
// tb/tb_exposure_readout_ctrl.sv - directed frame-timing bench for exposure_readout_ctrl
module tb_exposure_readout_ctrl;
   import cam_ctrl_pkg::*;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   always #5 Clk = ~Clk;

   exposure_readout_ctrl_if #(.NUM_ROWS(2), .EXP_W(5)) ifa();
   exposure_readout_ctrl_if #(.NUM_ROWS(4), .EXP_W(5)) ifb();

   exposure_readout_ctrl #(.NUM_ROWS(2), .EXP_W(5), .ADC_CYCLES(1)) dut_a (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (ifa.slave)
   );

   exposure_readout_ctrl #(.NUM_ROWS(4), .EXP_W(5), .ADC_CYCLES(3)) dut_b (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (ifb.slave)
   );

   int total = 0;
   int bad   = 0;
   int viol  = 0;

   logic [31:0] m_exp, m_adc, m_done, m_busy, m_erase, m_nre0, m_nre1, m_nre3, m_row;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (!Reset) begin
         if ($countones(~ifa.NRE) > 1 || (ifa.Expose && ifa.NRE != 2'b11))
            viol = viol + 1;
         if ($countones(~ifb.NRE) > 1 || (ifb.Expose && ifb.NRE != 4'hF))
            viol = viol + 1;
      end
   end

   // Bit k of each mask records the output during cycle k after the accepting edge.
   task automatic capture(input int which, input logic [4:0] et,
                          input logic [31:0] init_pat, input logic [31:0] abort_pat);
      m_exp = '0; m_adc = '0; m_done = '0; m_busy = '0; m_erase = '0;
      m_nre0 = '0; m_nre1 = '0; m_nre3 = '0; m_row = '0;
      @(negedge Clk);
      if (which == 0) begin ifa.Init = 1'b1; ifa.ExpTime = et; end
      else            begin ifb.Init = 1'b1; ifb.ExpTime = et; end
      @(posedge Clk);
      #1;
      ifa.Init = 1'b0; ifb.Init = 1'b0;
      for (int k = 1; k < 32; k++) begin
         @(negedge Clk);
         if (which == 0) begin
            m_exp[k]   = ifa.Expose;
            m_adc[k]   = ifa.ADC;
            m_done[k]  = ifa.Done;
            m_busy[k]  = ifa.Busy;
            m_erase[k] = ifa.Erase;
            m_nre0[k]  = ~ifa.NRE[0];
            m_nre1[k]  = ~ifa.NRE[1];
            m_row[k]   = (ifa.RowIdx == 1'b1);
            ifa.Init   = init_pat[k];
            ifa.Abort  = abort_pat[k];
         end else begin
            m_exp[k]   = ifb.Expose;
            m_adc[k]   = ifb.ADC;
            m_done[k]  = ifb.Done;
            m_busy[k]  = ifb.Busy;
            m_erase[k] = ifb.Erase;
            m_nre0[k]  = ~ifb.NRE[0];
            m_nre3[k]  = ~ifb.NRE[3];
            m_row[k]   = (ifb.RowIdx == 2'd3);
            ifb.Init   = init_pat[k];
            ifb.Abort  = abort_pat[k];
         end
      end
      ifa.Init = 1'b0; ifa.Abort = 1'b0;
      ifb.Init = 1'b0; ifb.Abort = 1'b0;
   endtask

   int pulses;

   initial begin
      ifa.Init = 1'b0; ifa.Abort = 1'b0; ifa.ExpTime = '0;
      ifb.Init = 1'b0; ifb.Abort = 1'b0; ifb.ExpTime = '0;
      Reset = 1'b1;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk("rst_erase",  ifa.Erase,  1);
      chk("rst_expose", ifa.Expose, 0);
      chk("rst_nre_a",  ifa.NRE,    2'b11);
      chk("rst_adc",    ifa.ADC,    0);
      chk("rst_busy",   ifa.Busy,   0);
      chk("rst_done",   ifa.Done,   0);
      chk("rst_rowidx", ifa.RowIdx, 0);
      chk("rst_nre_b",  ifb.NRE,    4'hF);
      Reset = 1'b0;

      capture(0, 5'd4, 32'h0, 32'h0);
      chk("nom_expose", m_exp,   32'h0000_001E);
      chk("nom_nre0",   m_nre0,  32'h0000_00E0);
      chk("nom_nre1",   m_nre1,  32'h0000_0E00);
      chk("nom_adc",    m_adc,   32'h0000_0440);
      chk("nom_done",   m_done,  32'h0000_2000);
      chk("nom_busy",   m_busy,  32'h0000_1FFE);
      chk("nom_erase",  m_erase, 32'hFFFF_E000);
      chk("nom_row1",   m_row,   32'h0000_1E00);

      capture(1, 5'd0, 32'h0, 32'h0);
      chk("swp_expose", m_exp,  32'h0000_0002);
      chk("swp_adc",    m_adc,  32'h00E3_8E38);
      chk("swp_done",   m_done, 32'h0400_0000);
      chk("swp_nre3",   m_nre3, 32'h01F0_0000);
      chk("swp_busy",   m_busy, 32'h03FF_FFFE);
      chk("swp_row3",   m_row,  32'h03F0_0000);
      pulses = 0;
      for (int k = 1; k < 32; k++)
         if (m_adc[k] && !m_adc[k-1]) pulses++;
      chk("swp_pulses", pulses, 4);

      capture(0, 5'd4, 32'h0000_0AAA, 32'h0);
      chk("tog_expose", m_exp,  32'h0000_001E);
      chk("tog_adc",    m_adc,  32'h0000_0440);
      chk("tog_done",   m_done, 32'h0000_2000);

      capture(0, 5'd4, 32'h0000_2000, 32'h0);
      chk("b2b_expose", m_exp,  32'h0003_C01E);
      chk("b2b_adc",    m_adc,  32'h0088_0440);
      chk("b2b_done",   m_done, 32'h0400_2000);

      capture(0, 5'd4, 32'h0, 32'h0000_0400);
      chk("abt_busy",  m_busy,  32'h0000_07FE);
      chk("abt_done",  m_done,  32'h0000_0000);
      chk("abt_adc",   m_adc,   32'h0000_0440);
      chk("abt_nre1",  m_nre1,  32'h0000_0600);
      chk("abt_erase", m_erase, 32'hFFFF_F800);
      capture(0, 5'd4, 32'h0, 32'h0);
      chk("abt_re_expose", m_exp,  32'h0000_001E);
      chk("abt_re_done",   m_done, 32'h0000_2000);

      @(negedge Clk);
      ifa.Init = 1'b1; ifa.Abort = 1'b1; ifa.ExpTime = 5'd4;
      @(negedge Clk);
      chk("abt_init_busy",   ifa.Busy,   0);
      chk("abt_init_expose", ifa.Expose, 0);
      ifa.Init = 1'b0; ifa.Abort = 1'b0;
      @(negedge Clk);
      chk("abt_init_noqueue", ifa.Busy, 0);

      @(negedge Clk);
      ifa.Init = 1'b1; ifa.ExpTime = 5'd4;
      @(posedge Clk);
      #1;
      ifa.Init = 1'b0;
      @(negedge Clk);
      chk("rmid_expose_pre", ifa.Expose, 1);
      Reset = 1'b1;
      @(negedge Clk);
      chk("rmid_erase",  ifa.Erase,  1);
      chk("rmid_expose", ifa.Expose, 0);
      chk("rmid_nre",    ifa.NRE,    2'b11);
      chk("rmid_adc",    ifa.ADC,    0);
      chk("rmid_busy",   ifa.Busy,   0);
      chk("rmid_done",   ifa.Done,   0);
      chk("rmid_rowidx", ifa.RowIdx, 0);
      Reset = 1'b0;
      capture(0, 5'd4, 32'h0, 32'h0);
      chk("rmid_re_expose", m_exp,  32'h0000_001E);
      chk("rmid_re_done",   m_done, 32'h0000_2000);

      chk("nre_invariant", viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
